// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
// The optional round-robin mode is selected with RAM_ARB_ROUND_ROBIN_EN.
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned GRANT_W    = 2;

  // Transfer sequencing: grant -> RAM strobe -> RAM latency -> acknowledge
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Requester identity; the value doubles as the bit index into a one-hot grant
  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } req_id_t;

  function automatic req_id_t grant_to_id(input logic [GRANT_W-1:0] grant);
    return grant[DBG] ? DBG : CPU;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-way grant select producing a one-hot grant (bit CPU / bit DBG).
// RAM_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise CPU has fixed priority.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic               cpu_req,
  input  logic               dbg_req,
  input  req_id_t            last_grant,
  output logic [GRANT_W-1:0] grant_c
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_c = '0;
    if (cpu_req && dbg_req) begin
      // Contention goes to whoever was not served last
      if (last_grant == CPU) grant_c[DBG] = 1'b1;
      else                   grant_c[CPU] = 1'b1;
    end else if (cpu_req) begin
      grant_c[CPU] = 1'b1;
    end else if (dbg_req) begin
      grant_c[DBG] = 1'b1;
    end
  end
`else
  logic unused_last_grant_c;
  assign unused_last_grant_c = last_grant;

  always_comb begin
    grant_c = '0;
    if (cpu_req)      grant_c[CPU] = 1'b1;
    else if (dbg_req) grant_c[DBG] = 1'b1;
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a CPU data port and a debug/loader port onto one synchronous RAM.
// RAM_ARB_ROUND_ROBIN_EN: round-robin on contention (default: CPU fixed priority).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  // CPU data port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  // debug / loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  // RAM side
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  state_t             state;
  state_t             state_d;
  logic [GRANT_W-1:0] grant_c;
  logic               grant_any_c;
  req_id_t            gnt_id;
  logic               gnt_we;
  req_id_t            last_grant;

  assign grant_any_c = (state == IDLE) && (|grant_c);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Starts at DBG so the first contention after reset goes to the CPU
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= DBG;
    end else if (grant_any_c) begin
      last_grant <= grant_to_id(grant_c);
    end
  end
`else
  assign last_grant = DBG;
`endif

  rr_arbiter2 u_rr_arbiter2 (
    .cpu_req    (cpu_req),
    .dbg_req    (dbg_req),
    .last_grant (last_grant),
    .grant_c    (grant_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (grant_any_c) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ram_address/ram_data double as the latched request; they only reload on a grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_id      <= CPU;
      gnt_we      <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      ram_rden    <= 1'b0;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
    end else begin
      ram_wren <= 1'b0;
      ram_rden <= 1'b0;
      cpu_ack  <= 1'b0;
      dbg_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any_c) begin
            gnt_id <= grant_to_id(grant_c);
            if (grant_c[DBG]) begin
              gnt_we      <= dbg_we;
              ram_address <= dbg_addr;
              ram_data    <= dbg_wdata;
              ram_wren    <= dbg_we;
              ram_rden    <= ~dbg_we;
            end else begin
              gnt_we      <= cpu_we;
              ram_address <= cpu_addr;
              ram_data    <= cpu_wdata;
              ram_wren    <= cpu_we;
              ram_rden    <= ~cpu_we;
            end
          end
        end
        WAIT: begin
          if (!gnt_we) begin
            if (gnt_id == DBG) dbg_rdata <= ram_q;
            else               cpu_rdata <= ram_q;
          end
        end
        DONE: begin
          cpu_ack <= (gnt_id == CPU);
          dbg_ack <= (gnt_id == DBG);
        end
        default: ;
      endcase
    end
  end

  // Freezes the CPU through its own access and while the debug port holds the RAM
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning RAM word width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have CPU data-port inputs cpu_req (1), cpu_we (1), cpu_addr (ADDR_W) and cpu_wdata (DATA_W).
REQ-006 The block SHALL have CPU data-port outputs cpu_rdata (DATA_W), cpu_ack (1) and cpu_stall (1).
REQ-007 The block SHALL have debug/loader-port inputs dbg_req (1), dbg_we (1), dbg_addr (ADDR_W) and dbg_wdata (DATA_W).
REQ-008 The block SHALL have debug/loader-port outputs dbg_rdata (DATA_W) and dbg_ack (1).
REQ-009 The block SHALL have RAM-side outputs ram_address (ADDR_W), ram_data (DATA_W), ram_rden (1) and ram_wren (1), and RAM-side input ram_q (DATA_W); ram_q is valid one cycle after the RAM samples its address.

Function
REQ-010 The block SHALL use FSM states IDLE, ISSUE, WAIT and DONE, each transition taken on one clk edge.
REQ-011 In IDLE with at least one request high, the block SHALL grant one requester and latch its we/addr/wdata into internal registers, then go to ISSUE; with no request it SHALL stay in IDLE.
REQ-012 In ISSUE the block SHALL drive ram_address and ram_data from the latched values and assert ram_wren (write) or ram_rden (read) for exactly that one cycle, then go to WAIT.
REQ-013 Outside ISSUE, ram_wren and ram_rden SHALL be 0, and ram_address and ram_data SHALL hold their last values.
REQ-014 On the WAIT to DONE edge, a granted read SHALL load ram_q into the granted port's rdata register; that register SHALL hold until that port's next read completes.
REQ-015 In DONE the block SHALL assert the granted port's ack (registered) for exactly one cycle, then return to IDLE.
REQ-016 Latency SHALL be request sampled in IDLE at edge E0, ack high in the cycle after E3, rdata valid from that cycle; maximum throughput is one access per 4 cycles.
REQ-017 A requester SHALL hold req until it sees ack; keeping req high after ack SHALL be treated as a new request in the following IDLE.
REQ-018 If req drops before ack, the latched transfer SHALL still complete and ack SHALL still pulse.
REQ-019 cpu_stall SHALL equal cpu_req AND NOT cpu_ack (combinational), so the CPU PC freezes during its own access and during dbg occupancy.
REQ-020 The ungranted port's ack SHALL stay 0, and its rdata SHALL be unchanged.

Reset
REQ-021 Reset low SHALL immediately force state IDLE, ram_wren=0, ram_rden=0, both acks 0, ram_address=0, ram_data=0, cpu_rdata=0, dbg_rdata=0, and last-grant=DBG.
REQ-022 Reset asserted mid-transfer SHALL abort it with no ack; a write aborted before the ISSUE edge SHALL not be committed.

Configuration
REQ-023 With RAM_ARB_ROUND_ROBIN_EN defined, on simultaneous requests in IDLE the block SHALL grant the port not granted last and update last-grant on every grant, so the first contention after reset goes to CPU.
REQ-024 Without RAM_ARB_ROUND_ROBIN_EN, CPU SHALL always win contention, dbg SHALL be served only when cpu_req is low, and the last-grant register SHALL be absent.

Structure
REQ-025 The shared package ram_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT/DONE), the requester-ID type (CPU/DBG) and the default ADDR_W/DATA_W constants.
REQ-026 The block SHALL contain one sub-module, rr_arbiter2: a 2-way grant select taking both reqs and last-grant and producing a one-hot grant, with fixed priority when the macro is undefined.

Verification
REQ-027 The bench SHALL cover CPU write then read: cpu write addr 0x005 data 0xDEADBEEF, then read 0x005 -> ram_wren exactly one cycle, cpu_ack 4 cycles after req, cpu_rdata=0xDEADBEEF.
REQ-028 The bench SHALL cover dbg alone: dbg write addr 0x3FF data 0x12345678 with cpu_req=0 -> dbg_ack one cycle, cpu_stall stays 0.
REQ-029 The bench SHALL cover simultaneous requests with the macro defined: cpu and dbg reads held high from reset -> grants CPU, DBG, CPU alternate, each ack 4 cycles apart, cpu_stall high while dbg is served.
REQ-030 The bench SHALL cover simultaneous requests with the macro undefined: same stimulus -> CPU granted every time, dbg_ack never until cpu_req drops.
REQ-031 The bench SHALL cover reset in WAIT: assert reset during a cpu read -> no ack, all outputs zero immediately, first post-reset request served normally.
REQ-032 The bench SHALL cover early req drop: cpu_req dropped one cycle after grant on write 0x0AA/0x1 -> write still committed, cpu_ack still pulses.
